// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and FSM state encoding for the scheduled Vedic multiplier
package vedic_pkg;

    localparam int OP_W   = 16;
    localparam int HALF_W = 8;
    localparam int PROD_W = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/vedic_8bit.sv
// rtl/vedic_8bit.sv - combinational 8x8 unsigned partial-product unit
module vedic_8bit
    import vedic_pkg::*;
(
    input  logic [HALF_W-1:0]   i_x,
    input  logic [HALF_W-1:0]   i_y,
    output logic [2*HALF_W-1:0] o_pp
);

    logic [7:0] w_ll;
    logic [7:0] w_lh;
    logic [7:0] w_hl;
    logic [7:0] w_hh;
    logic [8:0] w_cross;

    // Vertically-and-crosswise over nibbles: the two cross terms share one weight.
    assign w_ll    = {4'b0, i_x[3:0]} * {4'b0, i_y[3:0]};
    assign w_lh    = {4'b0, i_x[3:0]} * {4'b0, i_y[7:4]};
    assign w_hl    = {4'b0, i_x[7:4]} * {4'b0, i_y[3:0]};
    assign w_hh    = {4'b0, i_x[7:4]} * {4'b0, i_y[7:4]};
    assign w_cross = {1'b0, w_lh} + {1'b0, w_hl};

    assign o_pp = {8'b0, w_ll} + {3'b0, w_cross, 4'b0} + {w_hh, 8'b0};

endmodule

// File: rtl/vedic_mul_sched.sv
// rtl/vedic_mul_sched.sv - 16x16 multiplier sequencing four 8x8 partial products through one shared unit
module vedic_mul_sched
    import vedic_pkg::*;
#(
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    logic [1:0]          r_state;
    logic [1:0]          r_step;
    logic [PROD_W-1:0]   r_acc;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;

    logic [HALF_W-1:0]   w_x;
    logic [HALF_W-1:0]   w_y;
    logic [2*HALF_W-1:0] w_pp;
    logic [PROD_W-1:0]   w_pp_shifted;
    logic [PROD_W-1:0]   w_acc_next;
    logic                w_zero_op;

    always_comb begin
        w_x = r_a[HALF_W-1:0];
        w_y = r_b[HALF_W-1:0];
        case (r_step)
            2'd0: begin w_x = r_a[HALF_W-1:0];    w_y = r_b[HALF_W-1:0];    end
            2'd1: begin w_x = r_a[OP_W-1:HALF_W]; w_y = r_b[HALF_W-1:0];    end
            2'd2: begin w_x = r_a[HALF_W-1:0];    w_y = r_b[OP_W-1:HALF_W]; end
            default: begin w_x = r_a[OP_W-1:HALF_W]; w_y = r_b[OP_W-1:HALF_W]; end
        endcase
    end

    vedic_8bit u_pp (
        .i_x  (w_x),
        .i_y  (w_y),
        .o_pp (w_pp)
    );

    always_comb begin
        w_pp_shifted = {16'b0, w_pp};
        case (r_step)
            2'd0:    w_pp_shifted = {16'b0, w_pp};
            2'd1,
            2'd2:    w_pp_shifted = {8'b0, w_pp, 8'b0};
            default: w_pp_shifted = {w_pp, 16'b0};
        endcase
    end

    // Step 0 loads rather than accumulates, so no separate clear cycle is needed.
    assign w_acc_next = (r_step == 2'd0) ? w_pp_shifted : (r_acc + w_pp_shifted);
    assign w_zero_op  = (a == '0) || (b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= 2'd0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_step <= 2'd0;
                        if (BYPASS_ZERO && w_zero_op) begin
                            r_acc   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    r_acc  <= w_acc_next;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gating with rst_n keeps in_ready low for the whole reset pulse.
    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign p         = r_acc;

endmodule

// File: tb/tb_vedic_mul_sched.sv
// tb/tb_vedic_mul_sched.sv - directed and random self-checking bench for vedic_mul_sched
module tb_vedic_mul_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic [31:0] p;
    logic        in_valid_z, in_ready_z, out_valid_z, out_ready_z, busy_z;
    logic [15:0] a_z, b_z;
    logic [31:0] p_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vedic_mul_sched #(.BYPASS_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    vedic_mul_sched #(.BYPASS_ZERO(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_z), .in_ready(in_ready_z),
        .a(a_z), .b(b_z), .out_valid(out_valid_z), .out_ready(out_ready_z), .p(p_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts from IDLE with out_ready=1; latency counts edges from the transfer edge inclusive.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input int exp_lat, input logic [31:0] exp_p);
        int lat;
        a = ta; b = tb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_p"}, p, exp_p);
        tick();
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] ra, rb;
        logic [31:0] rexp;
        bit done;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        in_valid_z = 1'b0; out_ready_z = 1'b1; a_z = '0; b_z = '0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_p", p, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
        tick();

        run_op("ff_ff", 16'h00FF, 16'h00FF, 5, 32'h0000FE01);
        run_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 5, 32'hFFFE0001);
        run_op("bypass", 16'h1234, 16'h0000, 1, 32'h0);

        a_z = 16'h1234; b_z = 16'h0000; in_valid_z = 1'b1;
        tick();
        in_valid_z = 1'b0;
        lat = 1;
        while (!out_valid_z && lat < 20) begin
            tick();
            lat++;
        end
        check("nobypass_lat", lat, 32'd5);
        check("nobypass_p", p_z, 32'h0);
        tick();
        check("nobypass_in_ready", {31'b0, in_ready_z}, 32'd1);

        out_ready = 1'b0;
        a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        tick();
        a = 16'hFFFF; b = 16'hFFFF;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("stall_lat", lat, 32'd5);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stall_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("stall_p_%0d", i), p, 32'h06260060);
            check($sformatf("stall_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("stall_release_valid", {31'b0, out_valid}, 32'd0);
        check("stall_release_in_ready", {31'b0, in_ready}, 32'd1);

        a = 16'h0005; b = 16'h0007; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("pre_abort_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        check("abort_p", p, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("abort_rel_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort_no_valid_%0d", i), {31'b0, out_valid}, 32'd0);
            tick();
        end
        run_op("three_five", 16'd3, 16'd5, 5, 32'd15);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ra = '0;
            if ($urandom_range(0, 9) == 0) rb = '0;
            rexp = {16'b0, ra} * {16'b0, rb};
            a = ra; b = rb; in_valid = 1'b1;
            lat = 0;
            while (!in_ready && lat < 50) begin
                tick();
                lat++;
            end
            tick();
            a = 16'($urandom); b = 16'($urandom);
            done = 1'b0;
            lat = 0;
            while (!done && lat < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check($sformatf("rand_%0d_p", i), p, rexp);
                    done = 1'b1;
                end
                tick();
                lat++;
            end
            if (!done) check($sformatf("rand_%0d_timeout", i), 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
